// File: rtl/data_mem_access_pkg.sv
// data_mem_access_pkg
//   Shared definitions for the MEM-stage load/store unit: bit positions of
//   the decoder's one-hot l_s_type vector, bus size encodings, the access
//   FSM state type and small decode/format helpers.
package data_mem_access_pkg;

  localparam int DW = 32;

  // One-hot l_s_type bit positions: {lw,lh,lhu,lb,lbu,sw,sh,sb}
  localparam int LS_LW  = 7;
  localparam int LS_LH  = 6;
  localparam int LS_LHU = 5;
  localparam int LS_LB  = 4;
  localparam int LS_LBU = 3;
  localparam int LS_SW  = 2;
  localparam int LS_SH  = 1;
  localparam int LS_SB  = 0;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic is_load(input logic [7:0] t);
    return |t[LS_LW:LS_LBU];
  endfunction

  function automatic logic is_store(input logic [7:0] t);
    return |t[LS_SW:LS_SB];
  endfunction

  function automatic logic [1:0] size_of(input logic [7:0] t);
    logic [1:0] s;
    if (t[LS_LW] | t[LS_SW]) s = DSIZE_WORD;
    else if (t[LS_LH] | t[LS_LHU] | t[LS_SH]) s = DSIZE_HALF;
    else s = DSIZE_BYTE;
    return s;
  endfunction

  // Byte/half stores are replicated over every lane so the slave can pick
  // the lane from the address without a shifter on this side.
  function automatic logic [DW-1:0] store_data(input logic [7:0] t,
                                               input logic [DW-1:0] w);
    logic [DW-1:0] d;
    if (t[LS_SB]) d = {4{w[7:0]}};
    else if (t[LS_SH]) d = {2{w[15:0]}};
    else d = w;
    return d;
  endfunction

  function automatic logic align_err(input logic [7:0] t, input logic [1:0] a);
    logic word_s;
    logic half_s;
    word_s = t[LS_LW] | t[LS_SW];
    half_s = t[LS_LH] | t[LS_LHU] | t[LS_SH];
    return (word_s & (a != 2'd0)) | (half_s & a[0]);
  endfunction

endpackage

// File: rtl/data_mem_access_if.sv
// data_mem_access_if
//   Data-side SRAM-like bus (req/addr_ok/data_ok handshake).
//   master: drives data_req, data_wr, data_size, data_addr, data_wdata;
//           receives data_addr_ok, data_data_ok, data_rdata.
//   slave : the opposite directions.
interface data_mem_access_if;
  import data_mem_access_pkg::*;

  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_mem_access_mem_load_ext.sv
// mem_load_ext
//   Combinational load-data formatter: selects the byte/half lane from the
//   word-lane read data and sign- or zero-extends it.
//   in : l_s_type (one-hot op), addr_lo (addr[1:0]), rdata (32-bit word lane)
//   out: ext (32-bit extended result; lw and non-load ops pass rdata through)
module mem_load_ext
  import data_mem_access_pkg::*;
(
  input  logic [7:0]    l_s_type,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        unused_s;

  // Store bits and the lw bit are not needed here; lw takes the pass-through path.
  assign unused_s = ^{l_s_type[LS_LW], l_s_type[LS_SW:LS_SB]};

  // Byte lane select from the low address bits.
  always_comb begin
    byte_s = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
  end

  assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Extension according to the load flavour.
  always_comb begin
    ext = rdata;
    if (l_s_type[LS_LB]) ext = {{24{byte_s[7]}}, byte_s};
    else if (l_s_type[LS_LBU]) ext = {24'd0, byte_s};
    else if (l_s_type[LS_LH]) ext = {{16{half_s[15]}}, half_s};
    else if (l_s_type[LS_LHU]) ext = {16'd0, half_s};
    else ext = rdata;
  end

endmodule

// File: rtl/data_mem_access.sv
// data_mem_access
//   MEM-stage load/store unit. Checks alignment (adel/ades), issues the
//   access on the data bus, stalls IF..MEM until it completes and returns
//   the extended load data (registered) to MEM/WB.
//   clk, rst (sync, active-low); mem_valid, l_s_type, addr, wdata_in, flush
//   from the pipeline; stall, load_data, adel, ades, bad_addr to the
//   pipeline/CP0; bus: data-side SRAM-like master port.
//   A flush after the bus accepted the request cannot recall it, so the FSM
//   waits in WAIT with cancel set to swallow the orphan response.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [7:0]        l_s_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] wdata_in,
  input  logic              flush,
  output logic              stall,
  output logic [ADDR_W-1:0] load_data,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_addr,
  data_mem_access_if.master bus
);

  state_t            state_r, state_nxt_s;
  logic              cancel_r, cancel_nxt_s;
  logic [7:0]        type_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] wdata_r;
  logic [ADDR_W-1:0] load_data_r;
  logic [ADDR_W-1:0] ext_s;
  logic              err_s, start_s, latch_s, ld_upd_s, req_s, stall_s;

  assign err_s    = align_err(l_s_type, addr[1:0]);
  assign adel     = mem_valid & is_load(l_s_type) & err_s;
  assign ades     = mem_valid & is_store(l_s_type) & err_s;
  assign bad_addr = addr;
  assign start_s  = mem_valid & (|l_s_type) & ~err_s & ~flush;

  mem_load_ext u_ext (
    .l_s_type (type_r),
    .addr_lo  (addr_r[1:0]),
    .rdata    (bus.data_rdata),
    .ext      (ext_s)
  );

  // Next-state, handshake and stall decode.
  always_comb begin
    state_nxt_s  = state_r;
    cancel_nxt_s = cancel_r;
    stall_s      = 1'b0;
    req_s        = 1'b0;
    latch_s      = 1'b0;
    ld_upd_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = start_s;
        if (start_s) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        // addr_ok beats a simultaneous flush: the access is committed.
        if (bus.data_addr_ok) begin
          state_nxt_s  = ST_WAIT;
          cancel_nxt_s = flush;
        end else if (flush) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        // While cancelled only a newly arriving access is held off.
        stall_s = cancel_r ? start_s : 1'b1;
        if (bus.data_data_ok) begin
          if (cancel_r | flush) begin
            state_nxt_s  = ST_IDLE;
            cancel_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_HOLD;
            ld_upd_s    = is_load(type_r);
          end
        end else begin
          state_nxt_s  = ST_WAIT;
          cancel_nxt_s = cancel_r | flush;
        end
      end
      ST_HOLD: begin
        stall_s     = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        cancel_nxt_s = 1'b0;
      end
    endcase
  end

  // State, cancel flag, latched request fields and load result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cancel_r    <= 1'b0;
      type_r      <= 8'd0;
      addr_r      <= '0;
      size_r      <= 2'd0;
      wdata_r     <= '0;
      load_data_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      cancel_r <= cancel_nxt_s;
      if (latch_s) begin
        type_r  <= l_s_type;
        addr_r  <= addr;
        size_r  <= size_of(l_s_type);
        wdata_r <= store_data(l_s_type, wdata_in);
      end
      if (ld_upd_s) begin
        load_data_r <= ext_s;
      end
    end
  end

  assign stall          = stall_s;
  assign load_data      = load_data_r;
  assign bus.data_req   = req_s;
  assign bus.data_wr    = is_store(type_r);
  assign bus.data_size  = size_r;
  assign bus.data_addr  = addr_r;
  assign bus.data_wdata = wdata_r;

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;

  localparam logic [7:0] T_LW  = 8'h80;
  localparam logic [7:0] T_LH  = 8'h40;
  localparam logic [7:0] T_LHU = 8'h20;
  localparam logic [7:0] T_LB  = 8'h10;
  localparam logic [7:0] T_LBU = 8'h08;
  localparam logic [7:0] T_SW  = 8'h04;
  localparam logic [7:0] T_SH  = 8'h02;
  localparam logic [7:0] T_SB  = 8'h01;

  typedef struct {
    logic [7:0]  t;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] r;
    logic        el;
    logic        es;
    logic [1:0]  sz;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [7:0]  l_s_type;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        flush;
  logic        stall;
  logic [31:0] load_data;
  logic        adel;
  logic        ades;
  logic [31:0] bad_addr;

  int checks = 0;
  int errors = 0;

  data_mem_access_if bus_if ();

  data_mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .l_s_type  (l_s_type),
    .addr      (addr),
    .wdata_in  (wdata_in),
    .flush     (flush),
    .stall     (stall),
    .load_data (load_data),
    .adel      (adel),
    .ades      (ades),
    .bad_addr  (bad_addr),
    .bus       (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    l_s_type  = 8'h00;
    flush     = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
  endtask

  // Minimum-latency transaction (or alignment-fault check) for one vector.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    mem_valid = 1'b1;
    l_s_type  = v.t;
    addr      = v.a;
    wdata_in  = v.w;
    #1;
    chk({tag, "_adel"}, {31'd0, adel}, {31'd0, v.el});
    chk({tag, "_ades"}, {31'd0, ades}, {31'd0, v.es});
    chk({tag, "_bad_addr"}, bad_addr, v.a);
    if (v.el | v.es) begin
      chk({tag, "_err_stall"}, {31'd0, stall}, 32'd0);
      tick();
      chk({tag, "_err_noreq"}, {31'd0, bus_if.data_req}, 32'd0);
      chk({tag, "_err_ld"}, load_data, v.ld);
      idle_inputs();
    end else begin
      chk({tag, "_stall_c1"}, {31'd0, stall}, 32'd1);
      tick();
      bus_if.data_addr_ok = 1'b1;
      #1;
      chk({tag, "_req"}, {31'd0, bus_if.data_req}, 32'd1);
      chk({tag, "_stall_c2"}, {31'd0, stall}, 32'd1);
      chk({tag, "_wr"}, {31'd0, bus_if.data_wr}, {31'd0, v.wr});
      chk({tag, "_size"}, {30'd0, bus_if.data_size}, {30'd0, v.sz});
      chk({tag, "_daddr"}, bus_if.data_addr, v.a);
      chk({tag, "_wdata"}, bus_if.data_wdata, v.wd);
      tick();
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b1;
      bus_if.data_rdata   = v.r;
      #1;
      chk({tag, "_wait_req"}, {31'd0, bus_if.data_req}, 32'd0);
      chk({tag, "_stall_c3"}, {31'd0, stall}, 32'd1);
      tick();
      bus_if.data_data_ok = 1'b0;
      #1;
      chk({tag, "_hold_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_ld"}, load_data, v.ld);
      idle_inputs();
      tick();
    end
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{T_LW,  32'h1000_0004, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1]  = '{T_LB,  32'h1000_0003, 32'h0000_0000, 32'h8011_2233, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'hFFFF_FF80};
    vecs[2]  = '{T_LBU, 32'h1000_0003, 32'h0000_0000, 32'h8011_2233, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0080};
    vecs[3]  = '{T_LH,  32'h1000_0002, 32'h0000_0000, 32'h8011_2233, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'hFFFF_8011};
    vecs[4]  = '{T_LHU, 32'h1000_0002, 32'h0000_0000, 32'h8011_2233, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0000_8011};
    vecs[5]  = '{T_SH,  32'h1000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd1, 1'b1, 32'hABCD_ABCD, 32'h0000_8011};
    vecs[6]  = '{T_SB,  32'h2000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 1'b1, 32'hA5A5_A5A5, 32'h0000_8011};
    vecs[7]  = '{T_SW,  32'h2000_0008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd2, 1'b1, 32'hCAFE_F00D, 32'h0000_8011};
    vecs[8]  = '{T_LB,  32'h1000_0001, 32'h0000_0000, 32'h0000_7F00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_007F};
    vecs[9]  = '{T_LH,  32'h1000_0000, 32'h0000_0000, 32'h1234_F00F, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'hFFFF_F00F};
    vecs[10] = '{T_LW,  32'h1000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'hFFFF_F00F};
    vecs[11] = '{T_SH,  32'h1000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0000, 32'hFFFF_F00F};
    vecs[12] = '{T_LHU, 32'h1000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'hFFFF_F00F};
    vecs[13] = '{T_SW,  32'h1000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0000, 32'hFFFF_F00F};
    vecs[14] = '{T_LBU, 32'h1000_0002, 32'h0000_0000, 32'h00CD_0000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_00CD};

    rst = 1'b0;
    addr = 32'd0;
    wdata_in = 32'd0;
    bus_if.data_rdata = 32'd0;
    idle_inputs();
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, bus_if.data_req}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_daddr", bus_if.data_addr, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      run_vec(i, vecs[i]);
    end

    // addr_ok withheld for 5 cycles: request and fields must hold steady.
    mem_valid = 1'b1; l_s_type = T_LW; addr = 32'h1000_0010; wdata_in = 32'd0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold%0d_req", k), {31'd0, bus_if.data_req}, 32'd1);
      chk($sformatf("hold%0d_stall", k), {31'd0, stall}, 32'd1);
      chk($sformatf("hold%0d_daddr", k), bus_if.data_addr, 32'h1000_0010);
      chk($sformatf("hold%0d_size", k), {30'd0, bus_if.data_size}, 32'd2);
      tick();
    end
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata = 32'h0102_0304;
    tick();
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("hold_done_stall", {31'd0, stall}, 32'd0);
    chk("hold_done_ld", load_data, 32'h0102_0304);
    idle_inputs();
    tick();

    // Flush in the third REQ cycle before addr_ok: request dropped.
    mem_valid = 1'b1; l_s_type = T_LW; addr = 32'h1000_0014;
    tick();
    tick();
    tick();
    flush = 1'b1;
    mem_valid = 1'b0;
    #1;
    chk("rqfl_req", {31'd0, bus_if.data_req}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("rqfl_idle_req", {31'd0, bus_if.data_req}, 32'd0);
    chk("rqfl_idle_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("rqfl_still_idle", {31'd0, bus_if.data_req}, 32'd0);
    chk("rqfl_ld", load_data, 32'h0102_0304);

    // Flush in WAIT, orphan data_ok two cycles later, deferred new lw.
    mem_valid = 1'b1; l_s_type = T_LW; addr = 32'h1000_0020;
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    flush = 1'b1;
    mem_valid = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    chk("cxl_stall_free", {31'd0, stall}, 32'd0);
    tick();
    mem_valid = 1'b1; l_s_type = T_LW; addr = 32'h1000_0030;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata = 32'h0000_5555;
    #1;
    chk("cxl_defer_stall", {31'd0, stall}, 32'd1);
    chk("cxl_defer_noreq", {31'd0, bus_if.data_req}, 32'd0);
    tick();
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("cxl_ld_kept", load_data, 32'h0102_0304);
    chk("cxl_idle_stall", {31'd0, stall}, 32'd1);
    chk("cxl_idle_noreq", {31'd0, bus_if.data_req}, 32'd0);
    tick();
    bus_if.data_addr_ok = 1'b1;
    #1;
    chk("cxl_new_req", {31'd0, bus_if.data_req}, 32'd1);
    chk("cxl_new_addr", bus_if.data_addr, 32'h1000_0030);
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata = 32'h1111_2222;
    tick();
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("cxl_new_stall", {31'd0, stall}, 32'd0);
    chk("cxl_new_ld", load_data, 32'h1111_2222);
    idle_inputs();
    tick();

    // Reset in WAIT: everything clears and the late data_ok is ignored.
    mem_valid = 1'b1; l_s_type = T_LW; addr = 32'h1000_0040;
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    mem_valid = 1'b0;
    l_s_type = 8'h00;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("wrst_req", {31'd0, bus_if.data_req}, 32'd0);
    chk("wrst_stall", {31'd0, stall}, 32'd0);
    chk("wrst_ld", load_data, 32'd0);
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata = 32'h0000_AAAA;
    tick();
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("wrst_ignore_ld", load_data, 32'd0);
    chk("wrst_ignore_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("wrst_ignore_req", {31'd0, bus_if.data_req}, 32'd0);
    chk("wrst_ignore_ld2", load_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
